// File: rtl/accum_collector.sv
// Accumulates framed signed partial products into dot products and queues each completed sum
// in a small result FIFO. Define ACCUM_SAT_EN to make every add saturate instead of wrap.
module accum_collector #(
  parameter int IWIDTH     = 32,
  parameter int OWIDTH     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ivalid,
  input  logic [IWIDTH-1:0]             idata,
  input  logic                          accum_first,
  input  logic                          accum_last,
  output logic [OWIDTH-1:0]             odata,
  output logic                          ovalid,
  input  logic                          oready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          proto_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int MSB = OWIDTH - 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state;
  logic [OWIDTH-1:0]   acc;
  logic [OWIDTH-1:0]   term;
  logic [OWIDTH-1:0]   add_raw;
  logic [OWIDTH-1:0]   add_res;
  logic [OWIDTH-1:0]   sum;
  logic                start;
  logic                framing_bad;
  logic                push;
  logic                pop;
  logic                full;
  logic                wr_en;

  logic [OWIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  generate
    if (OWIDTH > IWIDTH) begin : g_ext
      assign term = {{(OWIDTH-IWIDTH){idata[IWIDTH-1]}}, idata};
    end else begin : g_noext
      assign term = idata;
    end
  endgenerate

  assign add_raw = acc + term;

`ifdef ACCUM_SAT_EN
  // Overflow only when both operands share a sign and the result's sign differs.
  logic add_ovf;
  assign add_ovf = (acc[MSB] == term[MSB]) && (add_raw[MSB] != acc[MSB]);
  assign add_res = !add_ovf ? add_raw :
                   (acc[MSB] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}});
`else
  assign add_res = add_raw;
`endif

  // A beat with no open sum starts one, framed correctly or not.
  assign start       = (state == IDLE) || accum_first;
  assign sum         = start ? term : add_res;
  assign framing_bad = ((state == IDLE) && !accum_first) || ((state == ACCUM) && accum_first);

  assign push  = ivalid && accum_last;
  assign pop   = ovalid && oready;
  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      proto_err <= 1'b0;
    end else if (ivalid) begin
      if (framing_bad) proto_err <= 1'b1;
      acc   <= sum;
      state <= accum_last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  assign ovalid = (fifo_count != '0);
  assign odata  = ovalid ? mem[rd_ptr] : '0;
  assign busy   = (state == ACCUM) || ovalid;

endmodule
